spi_slave_reg_bank: RTL and testbench

- Command/register-file stage directly downstream of the SPI slave byte engine.
- Consumes the received byte (spi_mosi_data, rx_complete) and parses a command byte plus data bytes into a local register file.
- Feeds the slave's transmit input (spi_miso_data) for the next byte of the frame.
- Lets an external SPI master read and write NUM_REGS control registers exposed to the rest of the FPGA.

---
 rtl/spi_slave_reg_bank_if.sv | 24 ++
 rtl/spi_slave_reg_bank.sv | 121 ++++++++++++
 tb/tb_spi_slave_reg_bank.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_reg_bank_if.sv
// Byte-level link between the SPI slave engine and the register bank.
// Carries chip select, the received byte strobe/data and the next MISO byte.
interface spi_slave_reg_bank_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic                    spi_cs;
    logic                    rx_complete;
    logic [PAYLOAD_BITS-1:0] spi_mosi_data;
    logic [PAYLOAD_BITS-1:0] spi_miso_data;

    modport master (
        output spi_cs,
        output rx_complete,
        output spi_mosi_data,
        input  spi_miso_data
    );

    modport slave (
        input  spi_cs,
        input  rx_complete,
        input  spi_mosi_data,
        output spi_miso_data
    );
endinterface

// File: rtl/spi_slave_reg_bank.sv
// SPI command parser and register file; define SPI_REG_BURST_EN to make
// the address pointer auto-increment after every data byte.
module spi_slave_reg_bank #(
    parameter int                      PAYLOAD_BITS = 8,
    parameter int                      NUM_REGS     = 16,
    parameter logic [PAYLOAD_BITS-1:0] RESET_VALUE  = '0,
    parameter logic [PAYLOAD_BITS-1:0] ID_BYTE      = 8'hA5
) (
    input  logic                             clk,
    input  logic                             rst,
    spi_slave_reg_bank_if.slave              bus,
    output logic [NUM_REGS*PAYLOAD_BITS-1:0] regs_flat,
    output logic                             wr_strobe,
    output logic [PAYLOAD_BITS-2:0]          wr_addr,
    output logic                             addr_err,
    output logic                             busy
);
    localparam int AW = PAYLOAD_BITS - 1;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AW:0] NR = (AW+1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

    state_t                  state;
    logic [PAYLOAD_BITS-1:0] regs [NUM_REGS];
    logic [AW-1:0]           addr_ptr;
    logic                    cs_m, cs_s, cs_d;
    logic                    cs_fall;
    logic [AW-1:0]           cmd_addr;
    logic [AW-1:0]           nxt_ptr;
    logic [AW-1:0]           rd_addr;
    logic                    rd_ok, wr_ok;
    logic [PAYLOAD_BITS-1:0] rd_data;

    assign cs_fall  = cs_d & ~cs_s;
    assign cmd_addr = bus.spi_mosi_data[AW-1:0];
    assign busy     = (state != IDLE);

`ifdef SPI_REG_BURST_EN
    assign nxt_ptr = addr_ptr + 1'b1;
`else
    assign nxt_ptr = addr_ptr;
`endif

    // The command byte reads from its own address; data bytes from the next pointer
    assign rd_addr = (state == CMD) ? cmd_addr : nxt_ptr;
    assign rd_ok   = ({1'b0, rd_addr} < NR);
    assign wr_ok   = ({1'b0, addr_ptr} < NR);
    assign rd_data = rd_ok ? regs[rd_addr[IW-1:0]] : '0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*PAYLOAD_BITS +: PAYLOAD_BITS] = regs[g];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_m              <= 1'b1;
            cs_s              <= 1'b1;
            cs_d              <= 1'b1;
            state             <= IDLE;
            addr_ptr          <= '0;
            bus.spi_miso_data <= ID_BYTE;
            wr_strobe         <= 1'b0;
            wr_addr           <= '0;
            addr_err          <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else begin
            cs_m      <= bus.spi_cs;
            cs_s      <= cs_m;
            cs_d      <= cs_s;
            wr_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= CMD;
                        addr_err <= 1'b0;
                    end
                end
                CMD: begin
                    if (bus.rx_complete) begin
                        addr_ptr <= cmd_addr;
                        if (bus.spi_mosi_data[PAYLOAD_BITS-1]) begin
                            state             <= READ;
                            bus.spi_miso_data <= rd_data;
                            if (!rd_ok) addr_err <= 1'b1;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.rx_complete) begin
                        if (wr_ok) begin
                            regs[addr_ptr[IW-1:0]] <= bus.spi_mosi_data;
                            wr_strobe              <= 1'b1;
                            wr_addr                <= addr_ptr;
                        end else begin
                            addr_err <= 1'b1;
                        end
                        addr_ptr <= nxt_ptr;
                    end
                end
                READ: begin
                    if (bus.rx_complete) begin
                        bus.spi_miso_data <= rd_data;
                        if (!rd_ok) addr_err <= 1'b1;
                        addr_ptr <= nxt_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
            // CS release wins over any state change; a coincident byte is still consumed above
            if (cs_s && state != IDLE) begin
                state             <= IDLE;
                bus.spi_miso_data <= ID_BYTE;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_reg_bank.sv
// Directed bench for spi_slave_reg_bank; expectations follow the
// SPI_REG_BURST_EN setting the bench is compiled with.
module tb_spi_slave_reg_bank;
    logic         clk;
    logic         rst;
    logic [127:0] regs_flat;
    logic         wr_strobe;
    logic [6:0]   wr_addr;
    logic         addr_err;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;
    logic [6:0] last_addr = '0;

    spi_slave_reg_bank_if #(.PAYLOAD_BITS(8)) bus ();

    spi_slave_reg_bank #(
        .PAYLOAD_BITS(8),
        .NUM_REGS    (16),
        .RESET_VALUE (8'h00),
        .ID_BYTE     (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .regs_flat(regs_flat),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .addr_err (addr_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            last_addr = wr_addr;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return regs_flat[i*8 +: 8];
    endfunction

    task automatic xfer(input logic [7:0] b, output logic [7:0] seen);
        repeat (2) @(negedge clk);
        seen = bus.spi_miso_data;
        repeat (8) @(negedge clk);
        bus.spi_mosi_data = b;
        bus.rx_complete   = 1'b1;
        @(negedge clk);
        bus.rx_complete   = 1'b0;
    endtask

    task automatic cs_low();
        bus.spi_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wr_frame(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] s;
        cs_low();
        xfer(a, s);
        xfer(d, s);
        cs_high();
    endtask

    initial begin
        logic [7:0] s0, s1, s2, s3;
        int cnt0;
        rst = 1'b0;
        bus.spi_cs        = 1'b1;
        bus.rx_complete   = 1'b0;
        bus.spi_mosi_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_miso", bus.spi_miso_data, 8'hA5);
        chk("rst_regs", regs_flat, 128'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", addr_err, 1'b0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_miso", bus.spi_miso_data, 8'hA5);
        chk("idle_busy", busy, 1'b0);
        chk("idle_strobe", strobe_cnt, 0);

        // single write {03, 5C}
        cs_low();
        xfer(8'h03, s0);
        xfer(8'h5C, s1);
        chk("wr_miso0", s0, 8'hA5);
        chk("wr_miso1", s1, 8'hA5);
        chk("wr_busy", busy, 1'b1);
        @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_drop", busy, 1'b0);
        chk("wr_reg3", reg_at(3), 8'h5C);
        chk("wr_cnt", strobe_cnt, 1);
        chk("wr_addr", last_addr, 7'd3);
        repeat (2) @(negedge clk);

        // read back a run of registers
        wr_frame(8'h02, 8'h11);
        wr_frame(8'h03, 8'h22);
        wr_frame(8'h04, 8'h33);
        chk("setup_cnt", strobe_cnt, 4);
        cs_low();
        xfer(8'h82, s0);
        xfer(8'h00, s1);
        xfer(8'h00, s2);
        xfer(8'h00, s3);
        cs_high();
        chk("rd_miso0", s0, 8'hA5);
        chk("rd_miso1", s1, 8'h11);
`ifdef SPI_REG_BURST_EN
        chk("rd_miso2", s2, 8'h22);
        chk("rd_miso3", s3, 8'h33);
`else
        chk("rd_miso2", s2, 8'h11);
        chk("rd_miso3", s3, 8'h11);
`endif
        chk("rd_cnt", strobe_cnt, 4);

        // top of the register file
        cs_low();
        xfer(8'h0F, s0);
        xfer(8'hAA, s0);
        xfer(8'hBB, s0);
        cs_high();
`ifdef SPI_REG_BURST_EN
        chk("oor_reg15", reg_at(15), 8'hAA);
        chk("oor_cnt", strobe_cnt, 5);
        chk("oor_err", addr_err, 1'b1);
`else
        chk("oor_reg15", reg_at(15), 8'hBB);
        chk("oor_cnt", strobe_cnt, 6);
        chk("oor_err", addr_err, 1'b0);
`endif
        cnt0 = strobe_cnt;
        wr_frame(8'h10, 8'h77);
        chk("oorw_err", addr_err, 1'b1);
        chk("oorw_cnt", strobe_cnt, cnt0);
        cs_low();
        chk("err_clear", addr_err, 1'b0);
        xfer(8'h90, s0);
        xfer(8'h00, s1);
        chk("oorr_miso", s1, 8'h00);
        chk("oorr_err", addr_err, 1'b1);
        cs_high();

        // abort mid data byte
        cnt0 = strobe_cnt;
        cs_low();
        xfer(8'h05, s0);
        repeat (4) @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_cnt", strobe_cnt, cnt0);
        chk("abort_reg5", reg_at(5), 8'h00);
        chk("abort_busy", busy, 1'b0);

        // async reset mid frame
        cs_low();
        xfer(8'h90, s0);
        chk("pre_rst_err", addr_err, 1'b1);
        chk("pre_rst_miso", bus.spi_miso_data, 8'h00);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_miso", bus.spi_miso_data, 8'hA5);
        chk("arst_busy", busy, 1'b0);
        chk("arst_err", addr_err, 1'b0);
        chk("arst_regs", regs_flat, 128'h0);
        chk("arst_waddr", wr_addr, 7'd0);
        bus.spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cnt0 = strobe_cnt;
        wr_frame(8'h01, 8'h66);
        chk("post_reg1", reg_at(1), 8'h66);
        chk("post_cnt", strobe_cnt, cnt0 + 1);
        chk("post_addr", last_addr, 7'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
